line_render_scheduler: RTL and testbench

- Sequences a renderer into the double-buffered VGA line buffer, one display line at a time.
- On each end-of-line blanking event it swaps the line-buffer bank and requests the next line from the renderer.
- It then streams the renderer's pixels into the write bank with sequential x addresses.
- Sits between the renderer pipeline and the VGA output block's line RAM write port; tracks completion and underruns.

---
 rtl/line_render_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_line_render_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_render_scheduler.sv
// Line render scheduler: on each end-of-line blanking edge, swaps the line-buffer bank,
// requests the next line from the renderer and streams its pixels into the write bank.
module line_render_scheduler #(
    parameter int LINE_WIDTH = 1024,
    parameter int NUM_LINES  = 768,
    parameter int X_WIDTH    = 12,
    parameter int Y_WIDTH    = 10,
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ENABLE,
    input  logic                  LINEEND_IN,
    input  logic                  FRAME_SYNC_IN,
    output logic                  REQ_OUT,
    output logic [Y_WIDTH-1:0]    REQ_Y_OUT,
    input  logic                  REQ_ACK_IN,
    input  logic                  PIX_VALID_IN,
    input  logic [DATA_WIDTH-1:0] PIX_DATA_IN,
    output logic                  PIX_READY_OUT,
    output logic                  ABORT_OUT,
    output logic                  BUF_WE_OUT,
    output logic [X_WIDTH-1:0]    BUF_X_OUT,
    output logic [DATA_WIDTH-1:0] BUF_DATA_OUT,
    output logic                  BUF_SEL_OUT,
    output logic                  BUSY_OUT,
    output logic [CNT_WIDTH-1:0]  UNDERRUN_CNT_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_STREAM  = 2'd2
    } state_t;

    localparam logic [X_WIDTH-1:0]   LAST_X  = X_WIDTH'(LINE_WIDTH - 1);
    localparam logic [X_WIDTH-1:0]   X_ONE   = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0]   LAST_Y  = Y_WIDTH'(NUM_LINES - 1);
    localparam logic [Y_WIDTH-1:0]   Y_ONE   = Y_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic                    lineend_q, lineend_d;
    logic                    pending_q, pending_d;
    logic [X_WIDTH-1:0]      x_q, x_d;
    logic [Y_WIDTH-1:0]      line_q, line_d;
    logic [Y_WIDTH-1:0]      req_y_q, req_y_d;
    logic                    sel_q, sel_d;
    logic                    req_q, req_d;
    logic                    busy_q, busy_d;
    logic                    abort_q, abort_d;
    logic                    we_q, we_d;
    logic [X_WIDTH-1:0]      buf_x_q, buf_x_d;
    logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic armed_edge;
    logic accept;
    logic last_pix;
    logic underrun;
    logic advance;

    // Event decode: an armed blanking edge, pixel handshake and the line-abort condition.
    always_comb begin
        armed_edge = LINEEND_IN & ~lineend_q & ENABLE;
        accept     = PIX_VALID_IN & (state_q == ST_STREAM);
        last_pix   = accept & (x_q == LAST_X);
        // A final pixel landing on the edge cycle wins: the line counts as complete.
        underrun   = armed_edge & (state_q != ST_IDLE) & ~last_pix;
    end

    // Next-state logic for the sequencer, pending flag, line counter and write pipeline.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        x_d        = x_q;
        line_d     = line_q;
        req_y_d    = req_y_q;
        sel_d      = sel_q;
        advance    = 1'b0;
        lineend_d  = LINEEND_IN;

        case (state_q)
            ST_IDLE: begin
                if (pending_q & ENABLE) begin
                    pending_d = 1'b0;
                    sel_d     = ~sel_q;
                    req_y_d   = line_q;
                    state_d   = ST_REQUEST;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (underrun) begin
                    advance = 1'b1;
                    state_d = ST_IDLE;
                end else if (REQ_ACK_IN) begin
                    x_d     = '0;
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_REQUEST;
                end
            end
            ST_STREAM: begin
                if (last_pix | underrun) begin
                    advance = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
                if (accept & ~last_pix) begin
                    x_d = x_q + X_ONE;
                end else begin
                    x_d = x_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disabling drops any latched request; an armed edge always re-arms it.
        if (!ENABLE) begin
            pending_d = 1'b0;
        end else if (armed_edge) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_d;
        end

        if (FRAME_SYNC_IN) begin
            line_d = '0;
        end else if (advance) begin
            line_d = (line_q == LAST_Y) ? '0 : (line_q + Y_ONE);
        end else begin
            line_d = line_q;
        end
    end

    // Registered outputs: write strobe one cycle after each handshake, status and counters.
    always_comb begin
        we_d       = accept;
        buf_x_d    = buf_x_q;
        buf_data_d = buf_data_q;
        if (accept) begin
            buf_x_d    = x_q;
            buf_data_d = PIX_DATA_IN;
        end else begin
            buf_x_d    = buf_x_q;
            buf_data_d = buf_data_q;
        end
        abort_d = underrun;
        if (underrun && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        req_d  = (state_d == ST_REQUEST);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            lineend_q  <= 1'b0;
            pending_q  <= 1'b0;
            x_q        <= '0;
            line_q     <= '0;
            req_y_q    <= '0;
            sel_q      <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            we_q       <= 1'b0;
            buf_x_q    <= '0;
            buf_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lineend_q  <= lineend_d;
            pending_q  <= pending_d;
            x_q        <= x_d;
            line_q     <= line_d;
            req_y_q    <= req_y_d;
            sel_q      <= sel_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            abort_q    <= abort_d;
            we_q       <= we_d;
            buf_x_q    <= buf_x_d;
            buf_data_q <= buf_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign REQ_OUT          = req_q;
    assign REQ_Y_OUT        = req_y_q;
    assign PIX_READY_OUT    = (state_q == ST_STREAM);
    assign ABORT_OUT        = abort_q;
    assign BUF_WE_OUT       = we_q;
    assign BUF_X_OUT        = buf_x_q;
    assign BUF_DATA_OUT     = buf_data_q;
    assign BUF_SEL_OUT      = sel_q;
    assign BUSY_OUT         = busy_q;
    assign UNDERRUN_CNT_OUT = cnt_q;

endmodule

// File: tb/tb_line_render_scheduler.sv
// Bench for line_render_scheduler: a randomized renderer plus a rule-level reference
// model of request, streaming, abort and line-numbering behaviour, checked every cycle.
module tb_line_render_scheduler;

    localparam int LW = 1024;
    localparam int NL = 768;
    localparam int XW = 12;
    localparam int YW = 10;
    localparam int DW = 12;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          lineend;
    logic          frame_sync;
    logic          req_out;
    logic [YW-1:0] req_y;
    logic          req_ack;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    logic          abort_out;
    logic          buf_we;
    logic [XW-1:0] buf_x;
    logic [DW-1:0] buf_data;
    logic          buf_sel;
    logic          busy_out;
    logic [CW-1:0] cnt_out;

    line_render_scheduler dut (
        .CLK              (clk),
        .RST_N            (rst_n),
        .ENABLE           (enable),
        .LINEEND_IN       (lineend),
        .FRAME_SYNC_IN    (frame_sync),
        .REQ_OUT          (req_out),
        .REQ_Y_OUT        (req_y),
        .REQ_ACK_IN       (req_ack),
        .PIX_VALID_IN     (pix_valid),
        .PIX_DATA_IN      (pix_data),
        .PIX_READY_OUT    (pix_ready),
        .ABORT_OUT        (abort_out),
        .BUF_WE_OUT       (buf_we),
        .BUF_X_OUT        (buf_x),
        .BUF_DATA_OUT     (buf_data),
        .BUF_SEL_OUT      (buf_sel),
        .BUSY_OUT         (busy_out),
        .UNDERRUN_CNT_OUT (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 waiting for ack, 2 streaming.
    int m_phase = 0, m_pend = 0, m_line = 0, m_y = 0, m_sel = 0, m_px = 0, m_cnt = 0;
    int le_prev = 0;
    int exp_we = 0, exp_abort = 0, exp_wx = 0, exp_wd = 0;

    // Renderer knobs and observation counters.
    int duty = 100, xmode = 1, ack_delay = 3, ack_wait = 0;
    int wr_count = 0, abort_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit hs, edge_e, final_pix, underrun, adv;
        logic [DW-1:0] d;
        hs     = (pix_valid === 1'b1) && (pix_ready === 1'b1);
        d      = pix_data;
        edge_e = lineend && (le_prev == 0) && enable;
        if (!rst_n) begin
            m_phase = 0; m_pend = 0; m_line = 0; m_y = 0; m_sel = 0; m_px = 0; m_cnt = 0;
            le_prev = 0; exp_we = 0; exp_abort = 0; exp_wx = 0; exp_wd = 0;
        end else begin
            final_pix = hs && (m_phase == 2) && (m_px == LW - 1);
            underrun  = edge_e && (m_phase != 0) && !final_pix;
            adv       = final_pix || underrun;
            exp_we    = hs;
            exp_abort = underrun;
            if (hs) begin
                exp_wx = m_px;
                exp_wd = d;
            end
            case (m_phase)
                0: if (enable && m_pend != 0) begin
                       m_phase = 1; m_sel = 1 - m_sel; m_y = m_line; m_pend = 0;
                   end
                1: if (underrun) m_phase = 0;
                   else if (req_ack) begin m_phase = 2; m_px = 0; end
                2: begin
                       if (hs && !final_pix) m_px++;
                       if (adv) m_phase = 0;
                   end
                default: m_phase = 0;
            endcase
            if (edge_e) m_pend = 1;
            if (!enable) m_pend = 0;
            if (frame_sync) m_line = 0;
            else if (adv) m_line = (m_line + 1) % NL;
            if (underrun && m_cnt < (1 << CW) - 1) m_cnt++;
            le_prev = lineend;
        end

        @(posedge clk);
        #1;
        chk("req",      req_out,   (m_phase == 1));
        chk("busy",     busy_out,  (m_phase != 0));
        chk("ready",    pix_ready, (m_phase == 2));
        chk("sel",      buf_sel,   m_sel);
        chk("req_y",    req_y,     m_y);
        chk("abort",    abort_out, exp_abort);
        chk("we",       buf_we,    exp_we);
        chk("buf_x",    buf_x,     exp_wx);
        chk("buf_data", buf_data,  exp_wd);
        chk("ucnt",     cnt_out,   m_cnt);
        if (buf_we === 1'b1) wr_count++;
        if (abort_out === 1'b1) abort_count++;

        // Renderer: ack after ack_delay cycles of request, random-duty pixel stream.
        if (req_out === 1'b1 && ack_wait >= ack_delay) req_ack = 1'b1;
        else req_ack = 1'b0;
        if (req_out === 1'b1) ack_wait++;
        else ack_wait = 0;
        pix_valid = ($urandom_range(99) < duty);
        pix_data  = (xmode != 0) ? DW'(m_px) : DW'($urandom);
    endtask

    task automatic edge_pulse();
        lineend = 1'b1;
        tick();
        lineend = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (req_out !== 1'b1 && n < 200) begin tick(); n++; end
        chk({tag, "_req_seen"}, req_out, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_out !== 1'b0 && n < 5000) begin tick(); n++; end
        chk({tag, "_idle_seen"}, busy_out, 0);
    endtask

    initial begin
        int n;
        int prev_y;
        bit saw_wrap;

        rst_n = 1'b0; enable = 1'b0; lineend = 1'b0; frame_sync = 1'b0;
        req_ack = 1'b0; pix_valid = 1'b0; pix_data = '0;

        // Reset with LINEEND toggling.
        lineend = 1'b1; tick();
        lineend = 1'b0; tick();
        chk("rst_req", req_out, 0);
        chk("rst_sel", buf_sel, 0);
        chk("rst_we",  buf_we,  0);
        chk("rst_cnt", cnt_out, 0);
        rst_n = 1'b1; enable = 1'b1;
        tick(); tick();

        // Nominal line 0: ack after 3 cycles, data = x.
        duty = 100; xmode = 1; ack_delay = 3;
        edge_pulse();
        wait_req("nom");
        chk("nom_y", req_y, 0);
        chk("nom_sel", buf_sel, 1);
        wr_count = 0;
        wait_idle("nom");
        chk("nom_writes", wr_count, LW);

        // Line 1 with 50% valid duty and random data.
        duty = 50; xmode = 0;
        edge_pulse();
        wait_req("bp");
        chk("bp_y", req_y, 1);
        chk("bp_sel", buf_sel, 0);
        wr_count = 0;
        wait_idle("bp");
        chk("bp_writes", wr_count, LW);

        // Line 2 aborted after 500 pixels; line 3 requested 2 cycles after the edge.
        duty = 100; xmode = 1;
        edge_pulse();
        wait_req("ur");
        chk("ur_y", req_y, 2);
        wr_count = 0; n = 0;
        while (wr_count < 500 && n < 2000) begin tick(); n++; end
        abort_count = 0;
        edge_pulse();
        chk("ur_abort_now", abort_out, 1);
        tick();
        chk("ur_req_2cyc", req_out, 1);
        chk("ur_next_y", req_y, 3);
        chk("ur_sel", buf_sel, 0);
        tick(); tick();
        chk("ur_abort_pulses", abort_count, 1);
        chk("ur_cnt", cnt_out, 1);
        wait_idle("ur");

        // Line 4: final pixel accepted on the edge cycle.
        edge_pulse();
        wait_req("co");
        n = 0;
        while (!(pix_ready === 1'b1 && pix_valid && m_px == LW - 1) && n < 2000) begin tick(); n++; end
        edge_pulse();
        chk("co_no_abort", abort_out, 0);
        chk("co_req_early", req_out, 0);
        tick();
        chk("co_req_2cyc", req_out, 1);
        chk("co_y", req_y, 5);
        chk("co_cnt", cnt_out, 1);

        // Line 5: ENABLE dropped mid-line still completes; edges then ignored.
        wr_count = 0; n = 0;
        while (wr_count < 100 && n < 500) begin tick(); n++; end
        enable = 1'b0;
        wait_idle("en");
        chk("en_writes", wr_count, LW);
        edge_pulse();
        repeat (6) tick();
        chk("en_off_noreq", req_out, 0);
        enable = 1'b1;
        repeat (6) tick();
        chk("en_on_noreq", req_out, 0);

        // Renderer never acks: each edge aborts and skips, walking the counter through the wrap.
        ack_delay = 1000000;
        saw_wrap = 0; prev_y = -1;
        for (int i = 0; i < 800 && !saw_wrap; i++) begin
            edge_pulse(); tick(); tick(); tick();
            if (req_out === 1'b1) begin
                if (prev_y == NL - 1 && req_y == 0) saw_wrap = 1;
                prev_y = int'(req_y);
            end
        end
        chk("wrap_767_to_0", saw_wrap, 1);

        // Frame sync coincident with the aborting edge at line 100.
        for (int i = 0; i < 200 && !(req_out === 1'b1 && req_y == 100); i++) begin
            edge_pulse(); tick(); tick(); tick();
        end
        chk("fs_at_100", req_y, 100);
        frame_sync = 1'b1;
        edge_pulse();
        frame_sync = 1'b0;
        tick(); tick(); tick();
        chk("fs_req", req_out, 1);
        chk("fs_y0", req_y, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
